// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_W   : operand / quotient width
//   CNT_W   : iteration counter width
//   state_t : controller states (IDLE, BUSY, DONE)
package divider_pkg;

    localparam int DIV_W = 4;
    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step of the divider (purely combinational).
// Ports:
//   rem_i  : current partial remainder
//   bit_i  : next dividend bit, shifted in at the LSB
//   div_i  : divisor
//   rem_o  : updated partial remainder
//   qbit_o : quotient bit produced by this step
module divider_step
    import divider_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [DIV_W-1:0] rem_o,
    output logic             qbit_o
);

    // One bit wider than the operands so the shifted remainder never overflows.
    logic [DIV_W:0] shifted;
    logic           ge;

    assign shifted = {rem_i, bit_i};
    assign ge      = (shifted >= {1'b0, div_i});
    assign qbit_o  = ge;
    // When the subtraction happens the difference is known to fit in DIV_W bits
    // (except for divide-by-zero, where the truncated value is never observable).
    assign rem_o   = ge ? DIV_W'(shifted - {1'b0, div_i}) : shifted[DIV_W-1:0];

endmodule

// File: rtl/divider_iterative_division_0_next.sv
// Unsigned 4-bit restoring divider behind ready/valid channels.
// One quotient bit per cycle, MSB first; one division in flight at a time.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   divider__lhs/_vld/_rdy : dividend channel
//   divider__rhs/_vld/_rdy : divisor channel
//   divider__result/_vld/_rdy : quotient channel
// Divide by zero yields 4'hF with normal latency; no error flag.
module divider_iterative_division_0_next
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divider__lhs,
    input  logic             divider__lhs_vld,
    output logic             divider__lhs_rdy,
    input  logic [DIV_W-1:0] divider__rhs,
    input  logic             divider__rhs_vld,
    output logic             divider__rhs_rdy,
    output logic [DIV_W-1:0] divider__result,
    output logic             divider__result_vld,
    input  logic             divider__result_rdy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [DIV_W-1:0] quo_q,   quo_d;
    logic [DIV_W-1:0] rem_q,   rem_d;
    logic [DIV_W-1:0] dvd_q,   dvd_d;
    logic [DIV_W-1:0] dvs_q,   dvs_d;

    logic [DIV_W-1:0] step_rem;
    logic             step_qbit;
    logic             accept;

    divider_step u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[cnt_q]),
        .div_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Both operands must be valid together; a lone valid consumes nothing.
    assign accept = (state_q == IDLE) && divider__lhs_vld && divider__rhs_vld;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d   = divider__lhs;
                    dvs_d   = divider__rhs;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(DIV_W - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rem_d        = step_rem;
                quo_d[cnt_q] = step_qbit;
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (divider__result_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and quotient: cleared by reset so an aborted division leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
        end
    end

    // Datapath: always reloaded on accept, so no reset needed.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dvd_q <= dvd_d;
        dvs_q <= dvs_d;
    end

    assign divider__lhs_rdy    = (state_q == IDLE) && !rst;
    assign divider__rhs_rdy    = (state_q == IDLE) && !rst;
    assign divider__result_vld = (state_q == DONE) && !rst;
    assign divider__result     = rst ? '0 : quo_q;

endmodule

// File: tb/tb_divider_iterative_division_0_next.sv
module tb_divider_iterative_division_0_next;

    logic       clk;
    logic       rst;
    logic [3:0] lhs;
    logic       lhs_vld;
    logic       lhs_rdy;
    logic [3:0] rhs;
    logic       rhs_vld;
    logic       rhs_rdy;
    logic [3:0] result;
    logic       result_vld;
    logic       result_rdy;

    int n_chk;
    int n_bad;

    divider_iterative_division_0_next dut (
        .clk                 (clk),
        .rst                 (rst),
        .divider__lhs        (lhs),
        .divider__lhs_vld    (lhs_vld),
        .divider__lhs_rdy    (lhs_rdy),
        .divider__rhs        (rhs),
        .divider__rhs_vld    (rhs_vld),
        .divider__rhs_rdy    (rhs_rdy),
        .divider__result     (result),
        .divider__result_vld (result_vld),
        .divider__result_rdy (result_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for result_vld (bounded); returns number of edges waited.
    task automatic wait_vld(output int lat);
        lat = 0;
        while (!result_vld && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full division with consumer always ready; checks rdy, latency, result, single vld cycle.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b, input int exp, input string tag);
        int lat;
        lhs = a; rhs = b; lhs_vld = 1'b1; rhs_vld = 1'b1; result_rdy = 1'b1;
        chk({tag, "_rdy"}, int'(lhs_rdy & rhs_rdy), 1);
        tick();                               // accept edge T
        lhs_vld = 1'b0; rhs_vld = 1'b0;
        chk({tag, "_busy_rdy"}, int'(lhs_rdy | rhs_rdy), 0);
        wait_vld(lat);
        chk({tag, "_lat"}, lat + 1, 5);
        chk({tag, "_q"}, int'(result), exp);
        tick();                               // handshake edge
        chk({tag, "_onevld"}, int'(result_vld), 0);
        chk({tag, "_idle"}, int'(lhs_rdy), 1);
    endtask

    initial begin
        int lat;
        n_chk = 0; n_bad = 0;
        rst = 1'b1; lhs = '0; rhs = '0; lhs_vld = 1'b0; rhs_vld = 1'b0; result_rdy = 1'b0;

        // Reset held one cycle
        tick();
        chk("rst_lhs_rdy", int'(lhs_rdy), 0);
        chk("rst_rhs_rdy", int'(rhs_rdy), 0);
        chk("rst_vld", int'(result_vld), 0);
        chk("rst_res", int'(result), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_res", int'(result), 0);

        // Basic functions
        do_div(4'd8, 4'd2, 4, "d8_2");
        do_div(4'd15, 4'd4, 3, "d15_4");
        do_div(4'd7, 4'd7, 1, "d7_7");
        do_div(4'd3, 4'd9, 0, "d3_9");
        do_div(4'd0, 4'd5, 0, "d0_5");
        do_div(4'd9, 4'd0, 15, "d9_0");
        do_div(4'd15, 4'd1, 15, "d15_1");

        // Backpressure: 13/3 held in DONE for 10 cycles
        lhs = 4'd13; rhs = 4'd3; lhs_vld = 1'b1; rhs_vld = 1'b1; result_rdy = 1'b0;
        tick();
        wait_vld(lat);
        chk("bp_lat", lat + 1, 5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", int'(result_vld), 1);
            chk("bp_q", int'(result), 4);
            chk("bp_rdy", int'(lhs_rdy | rhs_rdy), 0);
            tick();
        end
        lhs_vld = 1'b0; rhs_vld = 1'b0;
        chk("bp_still_vld", int'(result_vld), 1);
        result_rdy = 1'b1;
        tick();
        chk("bp_release_vld", int'(result_vld), 0);
        chk("bp_release_idle", int'(lhs_rdy & rhs_rdy), 1);

        // Valid skew: lhs alone for 3 cycles
        lhs = 4'd10; rhs = 4'd3; lhs_vld = 1'b1; rhs_vld = 1'b0; result_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("skew_rdy", int'(lhs_rdy & rhs_rdy), 1);
        end
        rhs_vld = 1'b1;
        tick();                               // accept 10/3
        chk("skew_accept", int'(lhs_rdy), 0);
        lhs = 4'd15; rhs = 4'd1;              // operands change while busy, valids stay up
        wait_vld(lat);
        chk("skew_lat", lat + 1, 5);
        chk("skew_q", int'(result), 3);
        lhs_vld = 1'b0; rhs_vld = 1'b0;
        tick();
        chk("skew_hold_q", int'(result), 3);
        result_rdy = 1'b1;
        tick();
        chk("skew_done", int'(result_vld), 0);

        // Reset mid-division
        lhs = 4'd14; rhs = 4'd3; lhs_vld = 1'b1; rhs_vld = 1'b1;
        tick();                               // accept
        lhs_vld = 1'b0; rhs_vld = 1'b0;
        tick();                               // second busy cycle
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", int'(lhs_rdy | rhs_rdy), 0);
        chk("mid_rst_vld", int'(result_vld), 0);
        chk("mid_rst_res", int'(result), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_idle", int'(lhs_rdy & rhs_rdy), 1);
        begin
            int spurious;
            spurious = 0;
            for (int i = 0; i < 8; i++) begin
                if (result_vld) spurious++;
                tick();
            end
            chk("mid_rst_no_vld", spurious, 0);
        end
        do_div(4'd12, 4'd5, 2, "d12_5");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
